// File: rtl/mux16_scan_ser.sv
// ============================================================================
//  Module   : mux16_scan_ser
//  Brief    : Word-to-serial scan controller driving an external 16:1 mux.
//             Optional parity slot enabled by defining MUX16_SCAN_PARITY_EN.
//  Revision : 1.0
// ============================================================================
`default_nettype none

module mux16_scan_ser #(
    parameter int MSB_FIRST = 0,
    parameter int IDLE_GAP  = 0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] in_data,
    input  logic        in_valid,
    output logic        in_ready,
    output logic [15:0] mux_in,
    output logic [3:0]  mux_sel,
    input  logic        mux_out,
    output logic        ser_bit,
    output logic        ser_valid,
    input  logic        ser_ready,
    output logic        ser_last,
    output logic        busy
);

`ifdef MUX16_SCAN_PARITY_EN
    localparam bit C_PAR = 1'b1;
`else
    localparam bit C_PAR = 1'b0;
`endif

    localparam logic [3:0] C_FIRST    = (MSB_FIRST != 0) ? 4'd15 : 4'd0;
    localparam logic [3:0] C_LAST     = (MSB_FIRST != 0) ? 4'd0  : 4'd15;
    localparam logic [3:0] C_GAP_LAST = 4'((IDLE_GAP > 0) ? (IDLE_GAP - 1) : 0);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_GAP   = 2'd2
    } state_t;

    state_t      r_state;
    logic [15:0] r_mux_in;
    logic [3:0]  r_sel;
    logic [3:0]  r_gap;
    logic        r_par;
    logic        r_par_slot;
    logic        r_in_ready;
    logic        r_ser_valid;
    logic        r_last;
    logic        r_busy;

    logic [3:0]  w_sel_next;
    logic        w_word_done;

    assign w_sel_next  = (MSB_FIRST != 0) ? (r_sel - 4'd1) : (r_sel + 4'd1);
    // End of word is the parity slot when enabled, otherwise the last data bit.
    assign w_word_done = ser_ready && (C_PAR ? r_par_slot : (r_sel == C_LAST));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_mux_in    <= 16'h0000;
            r_sel       <= C_FIRST;
            r_gap       <= 4'd0;
            r_par       <= 1'b0;
            r_par_slot  <= 1'b0;
            r_in_ready  <= 1'b1;
            r_ser_valid <= 1'b0;
            r_last      <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (in_valid) begin
                        r_mux_in    <= in_data;
                        r_sel       <= C_FIRST;
                        r_par       <= 1'b0;
                        r_par_slot  <= 1'b0;
                        r_last      <= 1'b0;
                        r_in_ready  <= 1'b0;
                        r_ser_valid <= 1'b1;
                        r_busy      <= 1'b1;
                        r_state     <= S_SHIFT;
                    end
                end
                S_SHIFT: begin
                    if (w_word_done) begin
                        r_sel       <= C_FIRST;
                        r_par_slot  <= 1'b0;
                        r_last      <= 1'b0;
                        r_ser_valid <= 1'b0;
                        if (IDLE_GAP > 0) begin
                            r_gap   <= 4'd0;
                            r_state <= S_GAP;
                        end else begin
                            r_in_ready <= 1'b1;
                            r_busy     <= 1'b0;
                            r_state    <= S_IDLE;
                        end
                    end else if (ser_ready) begin
                        r_par <= r_par ^ mux_out;
                        if (r_sel == C_LAST) begin
                            r_sel      <= C_FIRST;
                            r_par_slot <= 1'b1;
                            r_last     <= 1'b1;
                        end else begin
                            r_sel  <= w_sel_next;
                            r_last <= !C_PAR && (w_sel_next == C_LAST);
                        end
                    end
                end
                S_GAP: begin
                    if (r_gap == C_GAP_LAST) begin
                        r_in_ready <= 1'b1;
                        r_busy     <= 1'b0;
                        r_state    <= S_IDLE;
                    end else begin
                        r_gap <= r_gap + 4'd1;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign in_ready  = r_in_ready;
    assign mux_in    = r_mux_in;
    assign mux_sel   = r_sel;
    assign ser_bit   = (C_PAR && r_par_slot) ? r_par : mux_out;
    assign ser_valid = r_ser_valid;
    assign ser_last  = r_last;
    assign busy      = r_busy;

endmodule

`default_nettype wire

// File: tb/tb_mux16_scan_ser.sv
// ============================================================================
//  Module   : tb_mux16_scan_ser
//  Brief    : Directed self-checking bench for mux16_scan_ser (LSB-first and
//             MSB-first/IDLE_GAP=2 instances, each with a behavioural mux16).
//  Revision : 1.0
// ============================================================================
`default_nettype none

module tb_mux16_scan_ser;

`ifdef MUX16_SCAN_PARITY_EN
    localparam bit PAR = 1'b1;
`else
    localparam bit PAR = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    int          total = 0;
    int          bad   = 0;

    logic [15:0] a_in_data, a_mux_in, b_in_data, b_mux_in;
    logic [3:0]  a_mux_sel, b_mux_sel;
    logic        a_in_valid, a_in_ready, a_mux_out, a_ser_bit, a_ser_valid;
    logic        a_ser_ready, a_ser_last, a_busy;
    logic        b_in_valid, b_in_ready, b_mux_out, b_ser_bit, b_ser_valid;
    logic        b_ser_ready, b_ser_last, b_busy;

    always #5 clk = ~clk;

    assign a_mux_out = a_mux_in[a_mux_sel];
    assign b_mux_out = b_mux_in[b_mux_sel];

    mux16_scan_ser #(.MSB_FIRST(0), .IDLE_GAP(0)) u_a (
        .clk(clk), .rst(rst), .in_data(a_in_data), .in_valid(a_in_valid),
        .in_ready(a_in_ready), .mux_in(a_mux_in), .mux_sel(a_mux_sel),
        .mux_out(a_mux_out), .ser_bit(a_ser_bit), .ser_valid(a_ser_valid),
        .ser_ready(a_ser_ready), .ser_last(a_ser_last), .busy(a_busy)
    );

    mux16_scan_ser #(.MSB_FIRST(1), .IDLE_GAP(2)) u_b (
        .clk(clk), .rst(rst), .in_data(b_in_data), .in_valid(b_in_valid),
        .in_ready(b_in_ready), .mux_in(b_mux_in), .mux_sel(b_mux_sel),
        .mux_out(b_mux_out), .ser_bit(b_ser_bit), .ser_valid(b_ser_valid),
        .ser_ready(b_ser_ready), .ser_last(b_ser_last), .busy(b_busy)
    );

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        a_in_data = 16'h0; a_in_valid = 1'b0; a_ser_ready = 1'b1;
        b_in_data = 16'h0; b_in_valid = 1'b0; b_ser_ready = 1'b1;
        step;
        step;
        rst = 1'b0;
        total++;
        if ({a_in_ready, a_ser_valid, a_ser_last, a_busy, a_mux_in, a_mux_sel} !== {4'b1000, 16'h0, 4'd0}) begin
            bad++;
            $display("FAIL reset_a got=%0h exp=%0h", {a_in_ready, a_ser_valid, a_ser_last, a_busy, a_mux_in, a_mux_sel}, {4'b1000, 16'h0, 4'd0});
        end
        total++;
        if ({b_in_ready, b_ser_valid, b_ser_last, b_busy, b_mux_in, b_mux_sel} !== {4'b1000, 16'h0, 4'd15}) begin
            bad++;
            $display("FAIL reset_b got=%0h exp=%0h", {b_in_ready, b_ser_valid, b_ser_last, b_busy, b_mux_in, b_mux_sel}, {4'b1000, 16'h0, 4'd15});
        end
    endtask

    // Expected bit streams are listed in emission order.
    task automatic test_lsb;
        logic [0:15] e;
        e = 16'b0101000011111100;
        a_in_data = 16'h3F0A; a_in_valid = 1'b1;
        step;
        a_in_valid = 1'b0;
        total++;
        if ({a_mux_in, a_busy} !== {16'h3F0A, 1'b1}) begin
            bad++;
            $display("FAIL lsb_accept got=%0h exp=%0h", {a_mux_in, a_busy}, {16'h3F0A, 1'b1});
        end
        for (int i = 0; i < 16; i++) begin
            total++;
            if ({a_ser_valid, a_ser_last, a_in_ready, a_mux_sel, a_ser_bit} !== {1'b1, (i == 15) && !PAR, 1'b0, 4'(i), e[i]}) begin
                bad++;
                $display("FAIL lsb_bit%0d got=%0h exp=%0h", i, {a_ser_valid, a_ser_last, a_in_ready, a_mux_sel, a_ser_bit}, {1'b1, (i == 15) && !PAR, 1'b0, 4'(i), e[i]});
            end
            step;
        end
`ifdef MUX16_SCAN_PARITY_EN
        total++;
        if ({a_ser_valid, a_ser_last, a_ser_bit} !== 3'b110) begin
            bad++;
            $display("FAIL lsb_parity got=%0b exp=110", {a_ser_valid, a_ser_last, a_ser_bit});
        end
        step;
`endif
        total++;
        if ({a_ser_valid, a_in_ready, a_busy, a_ser_last, a_mux_sel} !== {4'b0100, 4'd0}) begin
            bad++;
            $display("FAIL lsb_end got=%0h exp=%0h", {a_ser_valid, a_in_ready, a_busy, a_ser_last, a_mux_sel}, {4'b0100, 4'd0});
        end
    endtask

    task automatic test_msb;
        logic [0:15] e;
        e = 16'b0011111100001010;
        b_in_data = 16'h3F0A; b_in_valid = 1'b1;
        step;
        b_in_valid = 1'b0;
        for (int i = 0; i < 16; i++) begin
            total++;
            if ({b_ser_valid, b_ser_last, b_in_ready, b_mux_sel, b_ser_bit} !== {1'b1, (i == 15) && !PAR, 1'b0, 4'(15 - i), e[i]}) begin
                bad++;
                $display("FAIL msb_bit%0d got=%0h exp=%0h", i, {b_ser_valid, b_ser_last, b_in_ready, b_mux_sel, b_ser_bit}, {1'b1, (i == 15) && !PAR, 1'b0, 4'(15 - i), e[i]});
            end
            step;
        end
`ifdef MUX16_SCAN_PARITY_EN
        total++;
        if ({b_ser_valid, b_ser_last, b_ser_bit} !== 3'b110) begin
            bad++;
            $display("FAIL msb_parity got=%0b exp=110", {b_ser_valid, b_ser_last, b_ser_bit});
        end
        step;
`endif
        for (int g = 0; g < 2; g++) begin
            total++;
            if ({b_ser_valid, b_in_ready, b_busy} !== 3'b001) begin
                bad++;
                $display("FAIL msb_gap%0d got=%0b exp=001", g, {b_ser_valid, b_in_ready, b_busy});
            end
            step;
        end
        total++;
        if ({b_ser_valid, b_in_ready, b_busy, b_mux_sel} !== {3'b010, 4'd15}) begin
            bad++;
            $display("FAIL msb_idle got=%0h exp=%0h", {b_ser_valid, b_in_ready, b_busy, b_mux_sel}, {3'b010, 4'd15});
        end
    endtask

    task automatic test_backpressure;
        logic [0:15] e;
        e = 16'b0101000011111100;
        a_in_data = 16'h3F0A; a_in_valid = 1'b1;
        step;
        a_in_valid = 1'b0;
        for (int i = 0; i < 16; i++) begin
            if (i == 6) begin
                a_ser_ready = 1'b0;
                for (int s = 0; s < 3; s++) begin
                    total++;
                    if ({a_ser_valid, a_mux_sel, a_ser_bit, a_mux_in} !== {1'b1, 4'd6, 1'b0, 16'h3F0A}) begin
                        bad++;
                        $display("FAIL bp_stall%0d got=%0h exp=%0h", s, {a_ser_valid, a_mux_sel, a_ser_bit, a_mux_in}, {1'b1, 4'd6, 1'b0, 16'h3F0A});
                    end
                    step;
                end
                a_ser_ready = 1'b1;
            end
            total++;
            if ({a_ser_valid, a_ser_last, a_mux_sel, a_ser_bit} !== {1'b1, (i == 15) && !PAR, 4'(i), e[i]}) begin
                bad++;
                $display("FAIL bp_bit%0d got=%0h exp=%0h", i, {a_ser_valid, a_ser_last, a_mux_sel, a_ser_bit}, {1'b1, (i == 15) && !PAR, 4'(i), e[i]});
            end
            step;
        end
`ifdef MUX16_SCAN_PARITY_EN
        total++;
        if ({a_ser_valid, a_ser_last, a_ser_bit} !== 3'b110) begin
            bad++;
            $display("FAIL bp_parity got=%0b exp=110", {a_ser_valid, a_ser_last, a_ser_bit});
        end
        step;
`endif
        total++;
        if ({a_ser_valid, a_in_ready} !== 2'b01) begin
            bad++;
            $display("FAIL bp_end got=%0b exp=01", {a_ser_valid, a_in_ready});
        end
    endtask

    task automatic test_mid_reset;
        a_in_data = 16'h3F0A; a_in_valid = 1'b1;
        step;
        a_in_valid = 1'b0;
        repeat (9) step;
        total++;
        if (a_mux_sel !== 4'd9) begin
            bad++;
            $display("FAIL mr_sel got=%0d exp=9", a_mux_sel);
        end
        rst = 1'b1;
        step;
        rst = 1'b0;
        total++;
        if ({a_ser_valid, a_in_ready, a_busy, a_ser_last, a_mux_in, a_mux_sel} !== {4'b0100, 16'h0, 4'd0}) begin
            bad++;
            $display("FAIL mr_state got=%0h exp=%0h", {a_ser_valid, a_in_ready, a_busy, a_ser_last, a_mux_in, a_mux_sel}, {4'b0100, 16'h0, 4'd0});
        end
        a_in_data = 16'h0001; a_in_valid = 1'b1;
        step;
        a_in_valid = 1'b0;
        for (int i = 0; i < 16; i++) begin
            total++;
            if ({a_ser_valid, a_ser_last, a_mux_sel, a_ser_bit} !== {1'b1, (i == 15) && !PAR, 4'(i), i == 0}) begin
                bad++;
                $display("FAIL mr_bit%0d got=%0h exp=%0h", i, {a_ser_valid, a_ser_last, a_mux_sel, a_ser_bit}, {1'b1, (i == 15) && !PAR, 4'(i), i == 0});
            end
            step;
        end
`ifdef MUX16_SCAN_PARITY_EN
        total++;
        if ({a_ser_valid, a_ser_last, a_ser_bit} !== 3'b111) begin
            bad++;
            $display("FAIL mr_parity got=%0b exp=111", {a_ser_valid, a_ser_last, a_ser_bit});
        end
        step;
`endif
        total++;
        if ({a_ser_valid, a_in_ready} !== 2'b01) begin
            bad++;
            $display("FAIL mr_end got=%0b exp=01", {a_ser_valid, a_in_ready});
        end
    endtask

    // in_valid stays high; in_data changes mid-scan and must be ignored.
    task automatic test_back_to_back;
        logic [15:0] words [2];
        words[0] = 16'hFFFF;
        words[1] = 16'h0000;
        b_in_data = words[0]; b_in_valid = 1'b1;
        step;
        b_in_data = words[1];
        for (int w = 0; w < 2; w++) begin
            if (w == 1) b_in_valid = 1'b0;
            total++;
            if (b_mux_in !== words[w]) begin
                bad++;
                $display("FAIL b2b_word%0d got=%0h exp=%0h", w, b_mux_in, words[w]);
            end
            for (int i = 0; i < 16; i++) begin
                total++;
                if ({b_ser_valid, b_ser_last, b_in_ready, b_mux_sel, b_ser_bit} !== {1'b1, (i == 15) && !PAR, 1'b0, 4'(15 - i), w == 0}) begin
                    bad++;
                    $display("FAIL b2b_w%0d_bit%0d got=%0h exp=%0h", w, i, {b_ser_valid, b_ser_last, b_in_ready, b_mux_sel, b_ser_bit}, {1'b1, (i == 15) && !PAR, 1'b0, 4'(15 - i), w == 0});
                end
                step;
            end
`ifdef MUX16_SCAN_PARITY_EN
            total++;
            if ({b_ser_valid, b_ser_last, b_ser_bit} !== 3'b110) begin
                bad++;
                $display("FAIL b2b_w%0d_parity got=%0b exp=110", w, {b_ser_valid, b_ser_last, b_ser_bit});
            end
            step;
`endif
            for (int g = 0; g < 2; g++) begin
                total++;
                if ({b_ser_valid, b_in_ready, b_busy} !== 3'b001) begin
                    bad++;
                    $display("FAIL b2b_w%0d_gap%0d got=%0b exp=001", w, g, {b_ser_valid, b_in_ready, b_busy});
                end
                step;
            end
            total++;
            if ({b_ser_valid, b_in_ready, b_busy} !== 3'b010) begin
                bad++;
                $display("FAIL b2b_w%0d_accept got=%0b exp=010", w, {b_ser_valid, b_in_ready, b_busy});
            end
            if (w == 0) step;
        end
    endtask

    initial begin
        test_reset;
        test_lsb;
        test_msb;
        test_backpressure;
        test_mid_reset;
        test_back_to_back;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
